slider_bcd_entry: RTL

Parametrised operand-entry block for the calculator datapath. It turns held slider switches into repeated decimal increments of N_OPERANDS packed-BCD operands, with ripple carry across N_DIGITS digits. It adds immediate first step, auto-repeat, wrap detection and clear, and sits between the board switch inputs and the calculator ALU/display path.

---
 rtl/slider_pkg.sv | 26 ++
 rtl/slider_bcd_entry_if.sv | 49 ++++
 rtl/bcd_digit_step.sv | 44 ++++
 rtl/slider_bcd_entry.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/slider_pkg.sv
// -----------------------------------------------------------------------------
// slider_pkg
// Shared types and helpers for the slider BCD operand-entry block.
//   state_e     : two-state FSM of the entry block (IDLE, HOLD)
//   bcd_digit_t : one packed BCD digit
//   cnt_width() : width of the auto-repeat counter for a given repeat period
// -----------------------------------------------------------------------------
package slider_pkg;

  // IDLE: no slider is up. HOLD: a slider is held and the repeat counter runs.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // The counter only ever holds 0..repeatCycles-1, so $clog2 bits are enough.
  // It is kept at least one bit wide so the declaration stays legal.
  function automatic int cnt_width(input int repeatCycles);
    int w;
    w = $clog2(repeatCycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/slider_bcd_entry_if.sv
// -----------------------------------------------------------------------------
// slider_bcd_entry_if
// Bundles the operand-entry signals between the board/calculator side (master)
// and the slider_bcd_entry block (slave).
//   slider              : raw slider levels, bit k adds 10^k
//   write_number_select : operand targeted by steps and clear
//   clear               : zero the selected operand and its overflow flag
//   number              : packed BCD operands, digit 0 in the LSBs
//   overflow            : sticky wrap flag per operand
//   step_pulse          : high in the cycle a step is applied
//   slider_dec          : subtract select, only when SLIDER_DECREMENT_EN is defined
// -----------------------------------------------------------------------------
interface slider_bcd_entry_if #(
  parameter int N_DIGITS   = 4,
  parameter int N_OPERANDS = 2,
  parameter int SEL_W      = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1
);

  logic [N_DIGITS-1:0]                     slider;
  logic [SEL_W-1:0]                        write_number_select;
  logic                                    clear;
  logic [N_OPERANDS-1:0][4*N_DIGITS-1:0]   number;
  logic [N_OPERANDS-1:0]                   overflow;
  logic                                    step_pulse;
`ifdef SLIDER_DECREMENT_EN
  logic                                    slider_dec;

  modport master (
    output slider, write_number_select, clear, slider_dec,
    input  number, overflow, step_pulse
  );

  modport slave (
    input  slider, write_number_select, clear, slider_dec,
    output number, overflow, step_pulse
  );
`else
  modport master (
    output slider, write_number_select, clear,
    input  number, overflow, step_pulse
  );

  modport slave (
    input  slider, write_number_select, clear,
    output number, overflow, step_pulse
  );
`endif

endinterface

// File: rtl/bcd_digit_step.sv
// -----------------------------------------------------------------------------
// bcd_digit_step
// Combinational single-digit BCD +1 / -1 stage used to build a ripple chain.
//   digit_i : current BCD digit (always a legal 0..9 value)
//   inc_i   : apply a unit step to this digit (carry/borrow in or step origin)
//   dec_i   : 1 = subtract one, 0 = add one
//   digit_o : resulting BCD digit
//   carry_o : carry (add) or borrow (subtract) into the next digit
// -----------------------------------------------------------------------------
module bcd_digit_step
  import slider_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  // 9+1 rolls to 0 with carry, 0-1 rolls to 9 with borrow; otherwise the
  // digit moves by one and nothing ripples upward.
  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (inc_i) begin
      if (dec_i) begin
        if (digit_i == 4'd0) begin
          digit_o = 4'd9;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end else begin
        if (digit_i >= 4'd9) begin
          digit_o = 4'd0;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/slider_bcd_entry.sv
// -----------------------------------------------------------------------------
// slider_bcd_entry
// Turns held slider switches into decimal steps on packed-BCD operands:
// immediate first step on press, auto-repeat every REPEAT_CYCLES while held,
// sticky wrap flag per operand and a per-operand clear.
//   clk       : system clock
//   rst_ext_n : asynchronous active-low reset (released synchronously upstream)
//   bus       : slider_bcd_entry_if.slave (sliders, select, clear, operands,
//               overflow flags, step_pulse)
// Optional feature: define SLIDER_DECREMENT_EN to add bus.slider_dec, which
// turns a step into a BCD subtract with borrow.
// -----------------------------------------------------------------------------
module slider_bcd_entry
  import slider_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int N_OPERANDS    = 2,
  parameter int REPEAT_CYCLES = 32500000,
  parameter int SEL_W         = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1
) (
  input  logic                clk,
  input  logic                rst_ext_n,
  slider_bcd_entry_if.slave   bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = cnt_width(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [N_DIGITS-1:0]                   syncMeta_q;
  logic [N_DIGITS-1:0]                   syncSlider_q;
  state_e                                state_q;
  logic [CNT_W-1:0]                      repeatCnt_q;
  logic [IDX_W-1:0]                      lastIdx_q;
  logic [N_OPERANDS-1:0][4*N_DIGITS-1:0] number_q;
  logic [N_OPERANDS-1:0]                 overflow_q;

  logic                                  anyHigh;
  logic [IDX_W-1:0]                      activeIdx;
  logic                                  stepNow;
  logic                                  selValid;
  logic                                  decMode;
  logic [4*N_DIGITS-1:0]                 curOperand;
  logic [4*N_DIGITS-1:0]                 nextOperand;
  logic [N_DIGITS-1:0]                   stepIn;
  logic [N_DIGITS:0]                     carry;

  // Two-flop synchroniser on every slider bit; nothing downstream looks at
  // the raw levels.
  always_ff @(posedge clk or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      syncMeta_q   <= '0;
      syncSlider_q <= '0;
    end else begin
      syncMeta_q   <= bus.slider;
      syncSlider_q <= syncMeta_q;
    end
  end

  // Lowest-numbered high slider wins; scanning downward lets the lowest
  // index overwrite any higher one.
  always_comb begin
    activeIdx = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (syncSlider_q[i]) begin
        activeIdx = IDX_W'(i);
      end
    end
  end

  assign anyHigh = |syncSlider_q;

  // A step fires on a fresh press, on a switch to a different active slider,
  // or when the repeat counter reaches its last value.
  always_comb begin
    stepNow = 1'b0;
    case (state_q)
      IDLE:    stepNow = anyHigh;
      HOLD:    stepNow = anyHigh &&
                         ((activeIdx != lastIdx_q) || (repeatCnt_q == CNT_LAST));
      default: stepNow = 1'b0;
    endcase
  end

  // FSM and repeat counter. lastIdx_q remembers which slider produced the
  // previous step so that a change of active slider counts as a new press.
  always_ff @(posedge clk or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      state_q     <= IDLE;
      repeatCnt_q <= '0;
      lastIdx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyHigh) begin
            state_q     <= HOLD;
            repeatCnt_q <= '0;
            lastIdx_q   <= activeIdx;
          end
        end
        HOLD: begin
          if (!anyHigh) begin
            state_q     <= IDLE;
            repeatCnt_q <= '0;
          end else if (stepNow) begin
            repeatCnt_q <= '0;
            lastIdx_q   <= activeIdx;
          end else begin
            repeatCnt_q <= repeatCnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          repeatCnt_q <= '0;
        end
      endcase
    end
  end

  assign selValid = (int'(bus.write_number_select) < N_OPERANDS);

`ifdef SLIDER_DECREMENT_EN
  assign decMode = bus.slider_dec;
`else
  assign decMode = 1'b0;
`endif

  assign curOperand = number_q[bus.write_number_select];
  assign carry[0]   = 1'b0;

  // Ripple chain: the unit step enters at the active digit; digits below it
  // see no step and no carry so they pass through unchanged.
  for (genvar g = 0; g < N_DIGITS; g++) begin : gDigit
    assign stepIn[g] = carry[g] | (activeIdx == IDX_W'(g));

    bcd_digit_step uStep (
      .digit_i (curOperand[4*g +: 4]),
      .inc_i   (stepIn[g]),
      .dec_i   (decMode),
      .digit_o (nextOperand[4*g +: 4]),
      .carry_o (carry[g+1])
    );
  end

  // Operand storage. Clear has priority over a coincident step; a carry or
  // borrow out of the top digit is dropped and recorded in the sticky flag.
  always_ff @(posedge clk or negedge rst_ext_n) begin
    if (!rst_ext_n) begin
      number_q   <= '0;
      overflow_q <= '0;
    end else if (selValid) begin
      if (bus.clear) begin
        number_q[bus.write_number_select]   <= '0;
        overflow_q[bus.write_number_select] <= 1'b0;
      end else if (stepNow) begin
        number_q[bus.write_number_select] <= nextOperand;
        if (carry[N_DIGITS]) begin
          overflow_q[bus.write_number_select] <= 1'b1;
        end
      end
    end
  end

  assign bus.number     = number_q;
  assign bus.overflow   = overflow_q;
  assign bus.step_pulse = stepNow && selValid;

endmodule
